// File: rtl/clock_set_controller.sv
`default_nettype none
// ============================================================================
// Module   : clock_set_controller
// Summary  : Two-button time-setting sequencer feeding digital_clock's load bus.
// Revision : 1.0 - initial release
// ============================================================================
module clock_set_controller #(
   parameter int REPEAT_CYCLES  = 5,
   parameter int TIMEOUT_CYCLES = 600,
   parameter int LOAD_CYCLES    = 2
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       btn_mode,
   input  logic       btn_inc,
   input  logic [3:0] cur_hours,
   input  logic [5:0] cur_minutes,
   input  logic [5:0] cur_seconds,
   output logic       adjust_clock,
   output logic [3:0] in_hours,
   output logic [5:0] in_minutes,
   output logic [5:0] in_seconds,
   output logic       set_mode,
   output logic [1:0] field_sel
);

   localparam int c_rep_w  = $clog2(REPEAT_CYCLES + 1);
   localparam int c_idle_w = $clog2(TIMEOUT_CYCLES + 1);
   localparam int c_load_w = $clog2(LOAD_CYCLES + 1);
   localparam logic [c_rep_w-1:0]  c_rep_last  = c_rep_w'(REPEAT_CYCLES - 1);
   localparam logic [c_idle_w-1:0] c_idle_last = c_idle_w'(TIMEOUT_CYCLES - 1);
   localparam logic [c_load_w-1:0] c_load_last = c_load_w'(LOAD_CYCLES - 1);

   typedef enum logic [2:0] {
      ST_RUN   = 3'd0,
      ST_SET_H = 3'd1,
      ST_SET_M = 3'd2,
      ST_SET_S = 3'd3,
      ST_LOAD  = 3'd4
   } state_t;

   state_t              r_state;
   state_t              w_state_nxt;
   logic [1:0]          r_mode_sync;
   logic [1:0]          r_inc_sync;
   logic                r_mode_prev;
   logic                r_inc_prev;
   logic [c_rep_w-1:0]  r_hold;
   logic [c_idle_w-1:0] r_idle;
   logic [c_load_w-1:0] r_load_cnt;
   logic [3:0]          r_hours;
   logic [5:0]          r_minutes;
   logic [5:0]          r_seconds;

   logic w_mode_press;
   logic w_inc_press;
   logic w_in_set;
   logic w_inc_act;
   logic w_repeat;
   logic w_bump;
   logic w_timeout;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_mode_sync <= 2'b00;
         r_inc_sync  <= 2'b00;
         r_mode_prev <= 1'b0;
         r_inc_prev  <= 1'b0;
      end else begin
         r_mode_sync <= {r_mode_sync[0], btn_mode};
         r_inc_sync  <= {r_inc_sync[0], btn_inc};
         r_mode_prev <= r_mode_sync[1];
         r_inc_prev  <= r_inc_sync[1];
      end
   end

   assign w_mode_press = r_mode_sync[1] & ~r_mode_prev;
   assign w_inc_press  = r_inc_sync[1] & ~r_inc_prev;
   assign w_in_set     = (r_state == ST_SET_H) || (r_state == ST_SET_M) || (r_state == ST_SET_S);
   // A mode press always wins over a coincident inc press or repeat.
   assign w_inc_act    = w_in_set & w_inc_press & ~w_mode_press;
   assign w_repeat     = w_in_set & r_inc_sync[1] & ~w_inc_press & ~w_mode_press
                         & (r_hold == c_rep_last);
   assign w_bump       = w_inc_act | w_repeat;
   assign w_timeout    = w_in_set & ~w_mode_press & ~w_inc_press & ~w_repeat
                         & (r_idle == c_idle_last);

   always_comb begin
      w_state_nxt  = r_state;
      adjust_clock = 1'b0;
      set_mode     = 1'b0;
      field_sel    = 2'd0;
      case (r_state)
         ST_RUN: begin
            if (w_mode_press) w_state_nxt = ST_SET_H;
         end
         ST_SET_H: begin
            set_mode  = 1'b1;
            field_sel = 2'd1;
            if (w_mode_press)   w_state_nxt = ST_SET_M;
            else if (w_timeout) w_state_nxt = ST_RUN;
         end
         ST_SET_M: begin
            set_mode  = 1'b1;
            field_sel = 2'd2;
            if (w_mode_press)   w_state_nxt = ST_SET_S;
            else if (w_timeout) w_state_nxt = ST_RUN;
         end
         ST_SET_S: begin
            set_mode  = 1'b1;
            field_sel = 2'd3;
            if (w_mode_press)   w_state_nxt = ST_LOAD;
            else if (w_timeout) w_state_nxt = ST_RUN;
         end
         ST_LOAD: begin
            adjust_clock = 1'b1;
            if (r_load_cnt == c_load_last) w_state_nxt = ST_RUN;
         end
         default: w_state_nxt = ST_RUN;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= ST_RUN;
      else        r_state <= w_state_nxt;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_hold     <= '0;
         r_idle     <= '0;
         r_load_cnt <= '0;
      end else begin
         if (!w_in_set || !r_inc_sync[1] || w_inc_press || w_mode_press || w_timeout || w_repeat)
            r_hold <= '0;
         else
            r_hold <= r_hold + c_rep_w'(1);

         if (!w_in_set || (w_state_nxt != r_state) || w_mode_press || w_inc_press || w_repeat)
            r_idle <= '0;
         else
            r_idle <= r_idle + c_idle_w'(1);

         if (w_state_nxt == ST_LOAD && r_state == ST_LOAD)
            r_load_cnt <= r_load_cnt + c_load_w'(1);
         else
            r_load_cnt <= '0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_hours   <= 4'd12;
         r_minutes <= 6'd0;
         r_seconds <= 6'd0;
      end else if (r_state == ST_RUN && w_mode_press) begin
         // Out-of-range running values are clamped so the shadow is always legal.
         r_hours   <= (cur_hours == 4'd0 || cur_hours > 4'd12) ? 4'd12 : cur_hours;
         r_minutes <= (cur_minutes > 6'd59) ? 6'd0 : cur_minutes;
         r_seconds <= (cur_seconds > 6'd59) ? 6'd0 : cur_seconds;
      end else if (w_bump) begin
         case (r_state)
            ST_SET_H: r_hours   <= (r_hours >= 4'd12)   ? 4'd1 : r_hours + 4'd1;
            ST_SET_M: r_minutes <= (r_minutes >= 6'd59) ? 6'd0 : r_minutes + 6'd1;
            ST_SET_S: r_seconds <= (r_seconds >= 6'd59) ? 6'd0 : r_seconds + 6'd1;
            default: ;
         endcase
      end
   end

   assign in_hours   = r_hours;
   assign in_minutes = r_minutes;
   assign in_seconds = r_seconds;

endmodule
`default_nettype wire

// File: doc/clock_set_controller.md
# clock_set_controller

Button-driven time-setting sequencer for the `digital_clock` counter block. It captures the running time from `digital_clock` and walks the user through hours, minutes and seconds fields using two push-buttons. It then drives `adjust_clock` and the `in_hours` / `in_minutes` / `in_seconds` load bus to commit the new time. It sits between the board buttons and `digital_clock`, in the same clock domain.

## Interface
- `REPEAT_CYCLES`, default 5: cycles of continuous `btn_inc` hold between auto-repeat increments.
- `TIMEOUT_CYCLES`, default 600: idle cycles in a set state before abandoning the edit.
- `LOAD_CYCLES`, default 2: cycles `adjust_clock` stays high when committing.
- `clk`  in  1  single system clock; all logic on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `btn_mode`  in  1  raw mode button, asynchronous to `clk`, active-high.
- `btn_inc`  in  1  raw increment button, asynchronous, active-high.
- `cur_hours`  in  4  running hours from `digital_clock` (1–12).
- `cur_minutes`  in  6  running minutes (0–59).
- `cur_seconds`  in  6  running seconds (0–59).
- `adjust_clock`  out  1  load strobe to `digital_clock`.
- `in_hours`  out  4  shadow hours / load value.
- `in_minutes`  out  6  shadow minutes / load value.
- `in_seconds`  out  6  shadow seconds / load value.
- `set_mode`  out  1  high in SET_H, SET_M and SET_S.
- `field_sel`  out  2  0 = RUN or LOAD, 1 = hours, 2 = minutes, 3 = seconds.

## Operation

**Input conditioning**
- Each button passes through a 2-flop synchronizer.
- A third flop holds the previous synced value. `press` = synced & ~previous.
- Synced level of `btn_inc` drives auto-repeat.

**FSM states: RUN, SET_H, SET_M, SET_S, LOAD.**
- RUN, mode press: capture `cur_*` into the shadow registers, then go to SET_H.
  - Hours of 0 or greater than 12 clamp to 12.
  - Minutes or seconds greater than 59 clamp to 0.
- SET_H, mode press: go to SET_M.
- SET_M, mode press: go to SET_S.
- SET_S, mode press: go to LOAD.
- LOAD: `adjust_clock` = 1 for exactly LOAD_CYCLES cycles, then RUN.
- Any SET state with idle counter reaching TIMEOUT_CYCLES: go to RUN with no load. The shadow retains its edited value, and `adjust_clock` stays 0.

**Increment (SET states only)**
- An inc press adds 1 to the selected field.
- Hours wrap 12→1; minutes and seconds wrap 59→0.

**Auto-repeat**
- The hold counter clears on an inc press.
- It counts while synced `btn_inc` is high in a SET state.
- On reaching REPEAT_CYCLES it issues one increment and clears.
- It clears when the button is released or the state changes.

**Idle counter**
- Clears on any press or repeat increment, and on SET state entry.
- Otherwise increments in SET states; held at 0 outside them.

**Conflicts and ignored inputs**
- Simultaneous mode and inc press: mode wins; the inc press is ignored and the hold counter clears.
- In RUN and LOAD, inc presses are ignored.
- In LOAD, mode presses are ignored.

**Outputs**
- `in_*` always reflect the shadow registers.
- `adjust_clock` is high only in LOAD.

**Reset (async, `rst_n` = 0)**
- State = RUN; `adjust_clock` = 0; `set_mode` = 0; `field_sel` = 0.
- Shadow: `in_hours` = 12, `in_minutes` = 0, `in_seconds` = 0.
- Synchronizers, previous flops and all counters = 0.
- Reset mid-LOAD aborts the strobe immediately.

## Timing
- A button level first sampled high at edge E0 produces an internal press during the E1–E2 cycle. The state, field and shadow update at E2, so the latency is 2 cycles.
- Capture on RUN→SET_H uses `cur_*` as sampled at the transition edge.
- Entry into LOAD at edge L:
  - `adjust_clock` is high from L to L+LOAD_CYCLES.
  - RUN is entered at L+LOAD_CYCLES.
  - `in_*` are stable throughout.
- Auto-repeat: first increment at the press edge, then one every REPEAT_CYCLES cycles of continuous hold.
- A button held across a state change does not re-press; a press requires a fresh low→high edge.

## Test plan
- **Reset.** Assert `rst_n` = 0 mid-run → `adjust_clock` = 0, `in_hours` = 12, `in_minutes` = 0, `in_seconds` = 0, `field_sel` = 0, asynchronously (before the next `clk` edge).
- **Capture and full edit.** `cur` = 1:59:00. Sequence: mode, inc×2 (hours), mode, inc×1 (minutes), mode, mode.
  - Required: `in_*` = 3:00:00 (minutes wrap 59→0).
  - `adjust_clock` is high for exactly 2 cycles.
  - Then RUN, and `digital_clock` shows 3:00:00.
- **Hours wrap and clamp.** `cur_hours` = 0 at capture → `in_hours` = 12. One inc → 1.
- **Auto-repeat.** Enter SET_S at 0 and hold `btn_inc` for 16 cycles after the press edge → seconds = 1 + 3 = 4 (REPEAT_CYCLES = 5). Release, then one inc press → 5.
- **Timeout.** Enter SET_M, then issue no presses for 600 cycles → `field_sel` = 0, `set_mode` = 0, and `adjust_clock` never asserts.
- **Conflicts.**
  - Mode and inc pressed on the same edge in SET_H → `field_sel` = 2, hours unchanged.
  - Mode pressed during LOAD → ignored.
  - `rst_n` pulse during LOAD → strobe ends immediately.
